// File: rtl/keypad_scan_ctrl_if.sv
// Keypad matrix lines plus game-core handshake of the Raiden keypad scanner.
// The master side is the scanner; the slave side is the keypad and the game core.
interface keypad_scan_ctrl_if;
    logic [3:0] keypadRow;
    logic [3:0] keypadCol;
    logic       fire_ack;
    logic [2:0] playerPos;
    logic       fire;
    logic [3:0] key_code;
    logic       key_valid;

    modport master (
        output keypadRow, playerPos, fire, key_code, key_valid,
        input  keypadCol, fire_ack
    );

    modport slave (
        input  keypadRow, playerPos, fire, key_code, key_valid,
        output keypadCol, fire_ack
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan, whole-frame debounce and press-edge decode driving the Raiden player ship.
// Define KEYPAD_AUTOREPEAT_EN to auto-repeat held left/right keys every REPEAT_CYCLES cycles.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int KEY_LEFT        = 4,
    parameter int KEY_RIGHT       = 6,
    parameter int KEY_FIRE        = 5,
    parameter int POS_INIT        = 3,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    keypad_scan_ctrl_if.master kp
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_state_t;

    row_state_t       row_q, row_d;
    logic [DIV_W-1:0] div_q;
    logic             div_done;
    logic             frame_done;
    logic [15:0]      frame_q, frame_next, frame_prev_q;
    logic [15:0]      stable_q, stable_prev_q;
    logic [15:0]      press;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_next;
    logic [3:0]       low_idx;
    logic             move_left, move_right;

    assign div_done   = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_done = div_done && (row_q == ROW3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) row_q <= ROW0;
        else      row_q <= row_d;
    end

    always_comb begin
        row_d = row_q;
        if (div_done) begin
            case (row_q)
                ROW0:    row_d = ROW1;
                ROW1:    row_d = ROW2;
                ROW2:    row_d = ROW3;
                ROW3:    row_d = ROW0;
                default: row_d = ROW0;
            endcase
        end
    end

    // Row drive is registered so it changes together with the row state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= '0;
            kp.keypadRow <= 4'b1110;
        end else if (div_done) begin
            div_q        <= '0;
            kp.keypadRow <= ~(4'b0001 << row_d);
        end else begin
            div_q        <= div_q + 1'b1;
        end
    end

    always_comb begin
        frame_next = frame_q;
        case (row_q)
            ROW0:    frame_next[3:0]   = ~kp.keypadCol;
            ROW1:    frame_next[7:4]   = ~kp.keypadCol;
            ROW2:    frame_next[11:8]  = ~kp.keypadCol;
            ROW3:    frame_next[15:12] = ~kp.keypadCol;
            default: frame_next        = frame_q;
        endcase
    end

    always_comb begin
        deb_cnt_next = '0;
        if (frame_next == frame_prev_q) begin
            if (deb_cnt_q == CNT_W'(DEBOUNCE_FRAMES)) deb_cnt_next = deb_cnt_q;
            else                                      deb_cnt_next = deb_cnt_q + 1'b1;
        end
    end

    // The stable vector only follows a frame after DEBOUNCE_FRAMES identical repeats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q       <= '0;
            frame_prev_q  <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            deb_cnt_q     <= '0;
        end else begin
            if (div_done) frame_q <= frame_next;
            if (frame_done) begin
                frame_prev_q <= frame_next;
                deb_cnt_q    <= deb_cnt_next;
                if (deb_cnt_next == CNT_W'(DEBOUNCE_FRAMES)) stable_q <= frame_next;
            end
            stable_prev_q <= stable_q;
        end
    end

    assign press = stable_q & ~stable_prev_q;

    always_comb begin
        low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (press[i]) low_idx = 4'(i);
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

    logic [REP_W-1:0] rep_cnt_q;
    logic             hold_left, hold_right, rep_clear, rep_step;

    assign hold_left  = stable_q[KEY_LEFT]  & ~stable_q[KEY_RIGHT];
    assign hold_right = stable_q[KEY_RIGHT] & ~stable_q[KEY_LEFT];
    assign rep_clear  = !(hold_left || hold_right) || press[KEY_LEFT] || press[KEY_RIGHT];
    assign rep_step   = !rep_clear && (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1));

    // Restarts on every press edge so the first repeat lands REPEAT_CYCLES after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          rep_cnt_q <= '0;
        else if (rep_clear) rep_cnt_q <= '0;
        else if (rep_step)  rep_cnt_q <= '0;
        else                rep_cnt_q <= rep_cnt_q + 1'b1;
    end

    assign move_left  = press[KEY_LEFT]  | (rep_step & hold_left);
    assign move_right = press[KEY_RIGHT] | (rep_step & hold_right);
`else
    assign move_left  = press[KEY_LEFT];
    assign move_right = press[KEY_RIGHT];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kp.playerPos <= 3'(POS_INIT);
            kp.fire      <= 1'b0;
            kp.key_code  <= '0;
            kp.key_valid <= 1'b0;
        end else begin
            kp.key_valid <= |press;
            if (|press) kp.key_code <= low_idx;

            if (move_left && !move_right) begin
                if (kp.playerPos != 3'd0) kp.playerPos <= kp.playerPos - 3'd1;
            end else if (move_right && !move_left) begin
                if (kp.playerPos != 3'd7) kp.playerPos <= kp.playerPos + 3'd1;
            end

            // A new fire press wins over a simultaneous acknowledge.
            if (press[KEY_FIRE])  kp.fire <= 1'b1;
            else if (kp.fire_ack) kp.fire <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized keypad bench for keypad_scan_ctrl against a frame-level reference model.
module tb_keypad_scan_ctrl;
    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_FRAMES = 2;
    localparam int KEY_LEFT        = 4;
    localparam int KEY_RIGHT       = 6;
    localparam int KEY_FIRE        = 5;
    localparam int POS_INIT        = 3;
    localparam int FRAME           = 4 * SCAN_DIV;

    localparam logic [15:0] K_LEFT  = 16'h0001 << KEY_LEFT;
    localparam logic [15:0] K_RIGHT = 16'h0001 << KEY_RIGHT;
    localparam logic [15:0] K_FIRE  = 16'h0001 << KEY_FIRE;

    logic        clk;
    logic        rst;
    logic [15:0] keys;
    logic [3:0]  colSense;

    keypad_scan_ctrl_if kif ();

    keypad_scan_ctrl #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
        .KEY_LEFT       (KEY_LEFT),
        .KEY_RIGHT      (KEY_RIGHT),
        .KEY_FIRE       (KEY_FIRE),
        .POS_INIT       (POS_INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a closed key pulls its column low while its row is driven low.
    always_comb begin
        colSense = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!kif.keypadRow[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c]) colSense[c] = 1'b0;
                end
            end
        end
    end
    assign kif.keypadCol = colSense;

    int          vectors;
    int          miscompares;
    int          k;
    logic        ackNow;
    logic        ackWithPress;
    logic [15:0] mPrev, mStable, mPending;
    int          mCnt;
    int          mPos;
    logic        mFire;
    logic [3:0]  mCode;
    logic        mValid;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, k, observed, expected);
        end
    endtask

    function automatic logic [3:0] lowestKey(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'h0;
    endfunction

    task automatic resetModel();
        k        = 0;
        mPrev    = '0;
        mStable  = '0;
        mPending = '0;
        mCnt     = 0;
        mPos     = POS_INIT;
        mFire    = 1'b0;
        mCode    = '0;
        mValid   = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_row",   32'(kif.keypadRow), 32'(4'b1110));
        checkOutput("rst_pos",   32'(kif.playerPos), 32'(POS_INIT));
        checkOutput("rst_fire",  32'(kif.fire),      32'(0));
        checkOutput("rst_code",  32'(kif.key_code),  32'(0));
        checkOutput("rst_valid", 32'(kif.key_valid), 32'(0));
    endtask

    // One clock: advance the frame-level model, then compare every output.
    task automatic stepCycle();
        logic [3:0] expRow;
        @(posedge clk);
        k++;
        mValid = 1'b0;
        if (mPending != 16'h0) begin
            mValid = 1'b1;
            mCode  = lowestKey(mPending);
            if (mPending[KEY_LEFT] && !mPending[KEY_RIGHT])      mPos = (mPos > 0) ? mPos - 1 : 0;
            else if (mPending[KEY_RIGHT] && !mPending[KEY_LEFT]) mPos = (mPos < 7) ? mPos + 1 : 7;
            if (mPending[KEY_FIRE]) mFire = 1'b1;
            else if (ackNow)        mFire = 1'b0;
        end else if (ackNow) begin
            mFire = 1'b0;
        end
        mPending = '0;
        if (k % FRAME == 0) begin
            if (keys == mPrev) mCnt = (mCnt < DEBOUNCE_FRAMES) ? mCnt + 1 : DEBOUNCE_FRAMES;
            else               mCnt = 0;
            mPrev = keys;
            if (mCnt == DEBOUNCE_FRAMES) begin
                mPending = keys & ~mStable;
                mStable  = keys;
            end
        end
        #1;
        expRow = ~(4'b0001 << ((k / SCAN_DIV) % 4));
        checkOutput("keypadRow", 32'(kif.keypadRow), 32'(expRow));
        checkOutput("key_valid", 32'(kif.key_valid), 32'(mValid));
        checkOutput("key_code",  32'(kif.key_code),  32'(mCode));
        checkOutput("playerPos", 32'(kif.playerPos), 32'(mPos));
        checkOutput("fire",      32'(kif.fire),      32'(mFire));
        ackNow       = (ackWithPress && mPending[KEY_FIRE]) || ($urandom_range(0, 15) == 0);
        kif.fire_ack = ackNow;
    endtask

    task automatic applyStimulus(input logic [15:0] newKeys, input int frames);
        keys = newKeys;
        repeat (frames * FRAME) stepCycle();
    endtask

    initial begin
        logic [15:0] pat;
        int          sel;
        int          nb;
        vectors      = 0;
        miscompares  = 0;
        ackWithPress = 1'b0;
        ackNow       = 1'b0;
        kif.fire_ack = 1'b0;
        keys         = '0;
        rst          = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkResetState();
        @(negedge clk);
        rst = 1'b1;
        resetModel();

        $display("[TB] idle scan");
        applyStimulus(16'h0, 3);

        $display("[TB] single right press held 5 frames");
        applyStimulus(K_RIGHT, 5);
        applyStimulus(16'h0, 4);

        $display("[TB] saturation right then left");
        repeat (5) begin applyStimulus(K_RIGHT, 3); applyStimulus(16'h0, 3); end
        repeat (8) begin applyStimulus(K_LEFT, 3);  applyStimulus(16'h0, 3); end

        $display("[TB] bouncing fire key");
        repeat (3) begin applyStimulus(K_FIRE, 1); applyStimulus(16'h0, 1); end
        applyStimulus(K_FIRE, 4);
        applyStimulus(16'h0, 3);
        ackWithPress = 1'b1;
        applyStimulus(K_FIRE, 4);
        ackWithPress = 1'b0;
        applyStimulus(16'h0, 3);

        $display("[TB] left and right together");
        applyStimulus(K_LEFT | K_RIGHT, 3);
        applyStimulus(16'h0, 3);

        $display("[TB] random key sessions");
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       pat = 16'h0001 << $urandom_range(0, 15);
                1:       pat = K_LEFT;
                2:       pat = K_RIGHT;
                3:       pat = K_FIRE;
                4:       pat = 16'($urandom) & 16'($urandom);
                default: pat = K_LEFT | K_FIRE;
            endcase
            ackWithPress = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                nb = $urandom_range(1, 3);
                repeat (nb) begin applyStimulus(pat, 1); applyStimulus(16'h0, 1); end
            end
            applyStimulus(pat, $urandom_range(1, 5));
            applyStimulus(16'h0, $urandom_range(1, 4));
        end
        ackWithPress = 1'b0;

        $display("[TB] reset during debounce");
        applyStimulus(16'h0, 4);
        applyStimulus(K_RIGHT, 1);
        repeat (FRAME / 2 + 3) stepCycle();
        rst          = 1'b0;
        kif.fire_ack = 1'b0;
        ackNow       = 1'b0;
        #1;
        checkResetState();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        resetModel();
        applyStimulus(K_RIGHT, 5);
        applyStimulus(16'h0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Upstream input stage of the Raiden game.
- Scans the 4x4 matrix keypad, debounces it, and turns key presses into the player ship row position and a fire request.
- Its outputs feed the game core's player position, bullet spawn and dot-matrix logic directly.
- Replaces ad-hoc polling with a defined scan/debounce/edge pipeline.

Parameters:
SCAN_DIV, 1000, clk cycles each keypad row is driven before its columns are sampled (min 2)
DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames required before the stable key vector updates (min 1)
KEY_LEFT, 4, key code (row*4+col) that moves the player toward row 0
KEY_RIGHT, 6, key code that moves the player toward row 7
KEY_FIRE, 5, key code that requests a bullet
POS_INIT, 3, player position after reset
REPEAT_CYCLES, 25000000, auto-repeat interval in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
keypadRow  output  4  row drive, one-hot active-low
keypadCol  input  4  column sense, active-low (0 = key closed)
fire_ack  input  1  one-cycle pulse from the game core: fire request consumed
playerPos  output  3  player ship row, 0..7
fire  output  1  sticky fire request
key_code  output  4  code of the most recent newly pressed key
key_valid  output  1  one-cycle pulse when key_code updates

Behaviour:
- Reset, asynchronous on rst low:
  - keypadRow = 4'b1110 (row 0 driven).
  - Row index 0, divider 0, raw/frame/stable vectors all 0, debounce count 0.
  - playerPos = POS_INIT, fire = 0, key_code = 0, key_valid = 0.
  - Reset mid-scan or mid-debounce discards all partial state; no press edge is produced on release of reset.
- Scan:
  - Row index r cycles 0→1→2→3→0.
  - keypadRow = ~(4'b0001 << r), registered output.
  - The divider counts 0..SCAN_DIV-1 per row.
  - On count SCAN_DIV-1: frame bits [4r+3:4r] <= ~keypadCol, then r advances and the divider clears.
  - One full frame = 4*SCAN_DIV cycles.
- Frame complete (sample of row 3):
  - If the new frame equals the previous frame, the debounce count increments (saturating at DEBOUNCE_FRAMES); otherwise it clears to 0.
  - When the count reaches DEBOUNCE_FRAMES, stable <= frame.
  - The stable vector therefore changes no earlier than DEBOUNCE_FRAMES+1 frames after a key change.
- Edge detect:
  - press = stable & ~stable_prev, evaluated in the cycle after a stable update, for exactly one cycle.
  - Releases produce nothing.
- key_code / key_valid:
  - If press != 0, key_code <= index of the lowest set bit and key_valid = 1 for that one cycle.
  - Simultaneous new presses report only the lowest code; all of them still act on position and fire.
- Position:
  - press[KEY_LEFT] alone: playerPos-1, saturating at 0.
  - press[KEY_RIGHT] alone: playerPos+1, saturating at 7.
  - Both in the same cycle: no change.
  - No wrap-around.
- Fire:
  - press[KEY_FIRE] sets fire; fire_ack clears it.
  - Set and ack in the same cycle: fire stays 1.
  - A second press while fire = 1 has no additional effect.
- All outputs are registered; there are no combinational paths from input to output.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined:
  - While stable[KEY_LEFT] or stable[KEY_RIGHT] is held alone, a repeat counter runs.
  - Every REPEAT_CYCLES cycles after the press edge, the block generates a synthetic move step with the same saturation rules.
  - The counter clears on release or when both keys are held.
  - Fire never auto-repeats.
- Undefined: no repeat counter is present; each press moves exactly one row.

Test Plan:
1. Reset (SCAN_DIV=4, DEBOUNCE_FRAMES=2), no keys held → keypadRow sequence 1110,1101,1011,0111, each held 4 cycles; playerPos=3, fire=0, key_valid never pulses.
2. Hold key 6 (row 1, col 2, keypadCol=1011 while row 1 driven) for 5 frames → exactly one key_valid with key_code=6, playerPos 3→4, no change on release.
3. Press key 6 five times, with release gaps ≥3 frames → playerPos 3→7 then stays 7; press key 4 eight times → playerPos reaches 0 and saturates.
4. Key 5 toggling every frame (bounce) for 6 frames, then held 4 frames → no key_valid during bounce; a single fire=1 after settling; fire_ack pulse → fire=0 next cycle; press edge coincident with fire_ack → fire remains 1.
5. Keys 4 and 6 pressed in the same frame → key_valid with key_code=4, playerPos unchanged.
6. Assert rst low mid-frame while key 6 is being debounced, release rst with key still held → playerPos=POS_INIT, scan restarts at row 0, one key_valid occurs only after a full DEBOUNCE_FRAMES of stable frames.
